uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single `uart_tx` serializer between `NUM_REQ` byte-stream requesters (pooling result streamer, status/debug sources) and sequences each byte through the `tx_enable` pulse / `tx_busy` wait handshake. Arbitration is round-robin at packet granularity: a granted requester holds the UART until it delivers a byte flagged `last`, or until it stalls past a timeout. Sits between the producer FSMs and the `uart_tx` instance, in the divided clock domain.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `STALL_MAX`, 1023: cycles a granted requester may withhold `req_valid` mid-packet before its lock is dropped; 0 disables the timeout.
- `clk`  in  1  system clock, the same divided clock that drives `uart_tx`.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester byte valid.
- `req_data`  in  NUM_REQ*8  requester i byte at bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte is the final byte of the packet; sampled with the byte.
- `req_ready`  out  NUM_REQ  one-hot byte accept.
- `tx_enable`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_data`  out  8  byte to `uart_tx`; stable from the pulse until the next load.
- `tx_busy`  in  1  from `uart_tx`.
- `grant_id`  out  3  current or most recent grantee.
- `active`  out  1  a packet lock is held.
- `stall_abort`  out  1  one-cycle pulse when the timeout drops a lock.

## Operation
- States: IDLE, TAG, ACCEPT, PULSE, SETTLE, WAIT.
- IDLE:
  - If any `req_valid` is high, pick a winner by round-robin, searching from `last_grant+1` with wrap-around.
  - Latch `grant_id`, set `active`=1, go to TAG (macro on) or ACCEPT.
  - With no `req_valid`, stay in IDLE.
- ACCEPT:
  - `req_ready[grant_id]`=1; every other `req_ready` bit is 0.
  - On `req_valid`&`req_ready`: register `tx_data` and `last_flag`, clear the stall counter, go to PULSE.
  - Otherwise increment the stall counter. At `STALL_MAX` (when nonzero): pulse `stall_abort`, set `last_grant`=`grant_id`, clear `active`, go to IDLE.
- PULSE: `tx_enable`=1 for exactly one cycle, then go to SETTLE.
- SETTLE: one dead cycle that covers the one-cycle `tx_busy` assertion latency of `uart_tx`; `tx_busy` is ignored here. Go to WAIT.
- WAIT: hold until `tx_busy`=0, then:
  - Tag just sent → ACCEPT.
  - `last_flag`=1 → set `last_grant`=`grant_id`, clear `active`, go to IDLE.
  - Otherwise → ACCEPT.
- Requests raised by non-granted requesters while a lock is held wait for the lock to end. There is no preemption.
- Simultaneous requests in IDLE are resolved by round-robin order only.
- `req_last` and `req_data` are ignored unless the byte is accepted.
- A zero-length packet is not possible: every packet carries at least one byte.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready`=0, `tx_enable`=0, `tx_data`=0x00, `grant_id`=0, `active`=0, `stall_abort`=0.
  - Stall counter 0, `last_grant`=`NUM_REQ-1`, so requester 0 wins first.
- Reset mid-packet: all of the above values apply on the next edge. Any byte already handed to `uart_tx` is not tracked.
- `tx_enable` and `req_ready` decode directly from the registered state, so they are glitch-free.
- Latency, macro off:
  - `req_valid` seen in IDLE at edge N.
  - `req_ready` high in cycle N+1.
  - `tx_enable` pulse in cycle N+2.
- Byte-to-byte spacing: byte time + 3 cycles (PULSE, SETTLE, WAIT exit).
- Stall counter width: `$clog2(STALL_MAX+1)`. It saturates at `STALL_MAX` and resets on every byte accept and on every grant.

## Configuration
- `UART_ARB_FRAME_TAG_EN` defined:
  - After each grant, TAG loads `tx_data` = `TAG_BASE` | `grant_id` (`TAG_BASE`=0xA0).
  - The tag goes through PULSE/SETTLE/WAIT before the first payload byte.
  - First-byte latency grows by one full byte transfer.
- Undefined: TAG is unreachable and the output stream is raw payload bytes.

## Structure
- Package `uart_arb_pkg`: state encoding, `TAG_BASE`, `GRANT_W`=3.
- Sub-module `rr_picker`: combinational round-robin priority. Inputs are `req_valid` and `last_grant`; outputs are the winner index and a `found` flag.
- Everything else lives in a single FSM in `uart_tx_arbiter`.

## Test plan
- Single-byte packet: req0 sends 0x5A with last=1 → `tx_enable` pulses 2 cycles after request, `tx_data`=0x5A, return to IDLE after `tx_busy` falls; `grant_id`=0.
- Contention: req0 and req1 both valid with 3-byte packets {0x01,0x02,0x03} / {0x11,0x12,0x13} → UART sees 01 02 03 11 12 13; a second round with both valid starts with req1… no: after req1 finishes `last_grant`=1, so next round starts with req0 → 01 02 03 11 12 13 again, never interleaved.
- Stall timeout: `STALL_MAX`=8, req1 sends one non-last byte then drops valid → `stall_abort` pulses after 8 ACCEPT cycles, `active`=0, pending req0 is granted next.
- Busy hold: model `uart_tx` holding `tx_busy` for 100 cycles → `req_ready` stays low through WAIT, exactly one `tx_enable` per byte, no byte lost or duplicated.
- Tag mode (`UART_ARB_FRAME_TAG_EN`): req1 sends 0x7E with last=1 → UART sees 0xA1 then 0x7E.
- Reset mid-packet: assert `rst` during WAIT of byte 2 of 4 → all outputs at reset values next cycle; req0 is then granted fresh.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared encodings for uart_tx_arbiter: FSM states, grant index width and frame tag base.
// The optional frame tag is enabled with UART_ARB_FRAME_TAG_EN.
package uart_arb_pkg;

  localparam int         GRANT_W  = 3;
  localparam logic [7:0] TAG_BASE = 8'hA0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG,
    S_ACCEPT,
    S_PULSE,
    S_SETTLE,
    S_WAIT
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin priority: first valid requester after last_grant, with wrap-around.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] winner,
  output logic               found
);

  // NOTE: every output is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req_valid[j] && (j == (int'(last_grant) + i) % NUM_REQ)) begin
          found  = 1'b1;
          winner = GRANT_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx between NUM_REQ byte streams.
// Define UART_ARB_FRAME_TAG_EN to prefix every packet with a TAG_BASE|grant_id byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int STALL_MAX = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_enable,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 active,
  output logic                 stall_abort
);

  localparam int             CNT_W   = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_MAX);

  state_t             state_q, state_d;
  logic [GRANT_W-1:0] grant_d;
  logic [GRANT_W-1:0] last_grant_q, last_grant_d;
  logic               active_d;
  logic [7:0]         tx_data_d;
  logic               last_flag_q, last_flag_d;
  logic               tag_sent_q, tag_sent_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d, cnt_inc;
  logic               stall_abort_d;

  logic [GRANT_W-1:0] winner;
  logic               found;
  logic               sel_valid;
  logic [7:0]         sel_data;
  logic               sel_last;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .winner     (winner),
    .found      (found)
  );

  // Grantee's lane and one-hot ready, both decoded from registered state only.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 8'h00;
    sel_last  = 1'b0;
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_id == GRANT_W'(j)) begin
        sel_valid    = req_valid[j];
        sel_data     = req_data[8*j +: 8];
        sel_last     = req_last[j];
        req_ready[j] = (state_q == S_ACCEPT);
      end
    end
  end

  assign tx_enable = (state_q == S_PULSE);
  assign cnt_inc   = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_id;
    last_grant_d  = last_grant_q;
    active_d      = active;
    tx_data_d     = tx_data;
    last_flag_d   = last_flag_q;
    tag_sent_d    = tag_sent_q;
    stall_cnt_d   = stall_cnt_q;
    stall_abort_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d     = winner;
          active_d    = 1'b1;
          stall_cnt_d = '0;
`ifdef UART_ARB_FRAME_TAG_EN
          state_d     = S_TAG;
`else
          state_d     = S_ACCEPT;
`endif
        end
      end
      S_TAG: begin
        tx_data_d  = TAG_BASE | 8'(grant_id);
        tag_sent_d = 1'b1;
        state_d    = S_PULSE;
      end
      S_ACCEPT: begin
        if (sel_valid) begin
          tx_data_d   = sel_data;
          last_flag_d = sel_last;
          stall_cnt_d = '0;
          state_d     = S_PULSE;
        end else if (STALL_MAX != 0) begin
          stall_cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            stall_abort_d = 1'b1;
            last_grant_d  = grant_id;
            active_d      = 1'b0;
            state_d       = S_IDLE;
          end
        end
      end
      S_PULSE:  state_d = S_SETTLE;
      // uart_tx raises busy one cycle after the pulse; busy is not trusted until WAIT.
      S_SETTLE: state_d = S_WAIT;
      S_WAIT: begin
        if (!tx_busy) begin
          if (tag_sent_q) begin
            tag_sent_d = 1'b0;
            state_d    = S_ACCEPT;
          end else if (last_flag_q) begin
            last_grant_d = grant_id;
            active_d     = 1'b0;
            state_d      = S_IDLE;
          end else begin
            state_d = S_ACCEPT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_id     <= '0;
      last_grant_q <= GRANT_W'(NUM_REQ - 1);
      active       <= 1'b0;
      tx_data      <= 8'h00;
      last_flag_q  <= 1'b0;
      tag_sent_q   <= 1'b0;
      stall_cnt_q  <= '0;
      stall_abort  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id     <= grant_d;
      last_grant_q <= last_grant_d;
      active       <= active_d;
      tx_data      <= tx_data_d;
      last_flag_q  <= last_flag_d;
      tag_sent_q   <= tag_sent_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_abort  <= stall_abort_d;
    end
  end

endmodule
